fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  IF stage of the RV32I core: owns the PC, fetches from instruction memory over a req/ack handshake,
//  and holds the IF/ID pipeline register whose opcode/funct3/funct7 fields feed control_unit.
//  Handles ID back-pressure (stall), branch/jump redirect (flush) and multi-cycle memory latency.
// PARAMETERS
//  XLEN      32            PC / address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk          in   1     clock, all state on rising edge
//  rst_n        in   1     asynchronous active-low reset
//  imem_req     out  1     fetch request; held until imem_ack
//  imem_addr    out  XLEN  fetch address; stable while imem_req=1
//  imem_ack     in   1     imem_rdata valid this cycle; completes request
//  imem_rdata   in   32    instruction word
//  stall        in   1     ID cannot accept; IF/ID outputs must hold
//  redirect     in   1     branch/jump taken: flush and restart at redirect_pc
//  redirect_pc  in   XLEN  new PC
//  id_valid     out  1     IF/ID holds a live instruction
//  id_instr     out  32    instruction
//  id_pc        out  XLEN  its address
//  id_pc_plus4  out  XLEN  id_pc+4
//  id_opcode    out  7     id_instr[6:0]
//  id_funct3    out  3     id_instr[14:12]
//  id_funct7    out  7     id_instr[31:25]
//  fetch_fault  out  1     misaligned redirect (see CONFIGURATION)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_instr=32'h0000_0013 (NOP),
//   id_pc=0, id_pc_plus4=0, held buffer empty, fetch_fault=0. Reset mid-request abandons it.
//  States: IDLE -> FETCH unconditionally (1 cycle). imem_req=1 only in FETCH and DROP.
//  FETCH: imem_addr=pc. On ack: stall=0 -> IF/ID<=rdata,pc; pc<=pc+4; stay FETCH
//   (back-to-back with single-cycle ack = 1 instr/cycle). stall=1 -> rdata,pc into held buffer, pc+=4, ->HOLD.
//  HOLD: imem_req=0; IF/ID frozen. When stall=0: IF/ID<=held buffer, ->FETCH.
//  DROP: request outstanding when redirect arrived; imem_addr=saved old address, req held;
//   on ack data discarded, ->FETCH at the new pc. Redirect in DROP only updates the target pc.
//  Redirect (priority over ack and stall): id_valid<=0, held buffer cleared, pc<=redirect_pc.
//   From FETCH with no ack this cycle ->DROP; with ack ->FETCH (data dropped); from HOLD/IDLE ->FETCH.
//  stall=1: id_* outputs hold value. stall=0 and no new instr: id_valid<=0 (bubble), id_* data don't-care.
//  Arithmetic: pc+4 modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0. Addresses are word-aligned.
//  First imem_req asserted 1 cycle after rst_n release; first id_valid 1 cycle after first ack.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: redirect with redirect_pc[1:0]!=0 sets fetch_fault (sticky); any
//   outstanding request completes (DROP semantics), then no new requests and id_valid=0 until an
//   aligned redirect, which clears fetch_fault and resumes FETCH at that pc.
//  Not defined: redirect_pc[1:0] forced to 2'b00; fetch_fault tied 0.
// TESTING
//  Reset, ack every cycle, mem[0..3]=0x00500093,... -> imem_addr 0,4,8,C; id_pc 0,4,8 one cycle later; id_opcode=7'h13.
//  Ack 3 cycles after req -> imem_req/imem_addr stable 3 cycles; id_valid pulses once per ack.
//  stall=1 for 4 cycles while ack at addr 0x8 -> id_* frozen, state HOLD, req=0; stall drop -> id_pc=0x8 next cycle.
//  redirect to 0x100 while req to 0x10 pending (ack 2 later) -> id_valid=0, 0x10 data never in IF/ID, next req addr 0x100.
//  Redirect to 0xFFFF_FFFC -> next fetch addr 0x0; simultaneous redirect+ack+stall -> flush wins, id_valid=0.
//  MISALIGN_TRAP_EN: redirect 0x102 -> fetch_fault=1, no req; redirect 0x200 -> fault clears, fetch 0x200.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch stage of the RV32I core. Owns the PC,
//                fetches from instruction memory over a req/ack handshake and
//                holds the IF/ID pipeline register. It handles back-pressure
//                from ID (stall), branch/jump redirect (flush) and memory
//                replies that take several cycles.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    XLEN        PC / address width
//    RESET_PC    first fetch address after reset
//  Ports
//    clk, rst_n             clock (rising edge), asynchronous active-low reset
//    imem_req/imem_addr     fetch request and address, held until imem_ack
//    imem_ack/imem_rdata    request completion and instruction word
//    stall                  ID cannot accept; IF/ID outputs hold
//    redirect/redirect_pc   taken branch/jump: flush and restart at redirect_pc
//    id_valid, id_instr, id_pc, id_pc_plus4   IF/ID pipeline register
//    id_opcode/id_funct3/id_funct7            decode fields of id_instr
//    fetch_fault            sticky misaligned-redirect flag
//  Configuration macro
//    MISALIGN_TRAP_EN  defined    : a misaligned redirect sets fetch_fault and
//                                   stops fetching until an aligned redirect.
//                      undefined  : redirect_pc[1:0] forced to 0, fetch_fault=0.
// ============================================================================
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus4,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7,
    output logic            fetch_fault
);

    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,   // instruction parked in the held buffer during stall
        DROP  = 2'd3    // stale request still outstanding after a redirect
    } state_t;

    state_t          state_q,       state_d;
    logic [XLEN-1:0] pc_q,          pc_d;
    logic [XLEN-1:0] drop_addr_q,   drop_addr_d;
    logic [31:0]     held_instr_q,  held_instr_d;
    logic [XLEN-1:0] held_pc_q,     held_pc_d;
    logic            id_valid_q,    id_valid_d;
    logic [31:0]     id_instr_q,    id_instr_d;
    logic [XLEN-1:0] id_pc_q,       id_pc_d;
    logic [XLEN-1:0] id_pc_plus4_q, id_pc_plus4_d;
    logic            fault_q,       fault_d;

    logic [XLEN-1:0] target_pc;
    logic            target_misaligned;
    logic            ack_ok;

`ifdef MISALIGN_TRAP_EN
    assign target_pc         = redirect_pc;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign target_pc         = redirect_pc & ALIGN_MSK;
    assign target_misaligned = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drop_addr_q   <= RESET_PC;
            held_instr_q  <= NOP_INSTR;
            held_pc_q     <= '0;
            id_valid_q    <= 1'b0;
            id_instr_q    <= NOP_INSTR;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_addr_q   <= drop_addr_d;
            held_instr_q  <= held_instr_d;
            held_pc_q     <= held_pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fault_q       <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_addr_d   = drop_addr_q;
        held_instr_d  = held_instr_q;
        held_pc_d     = held_pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fault_d       = fault_q;

        // A faulted FETCH issues nothing; DROP always finishes its request.
        imem_req  = (state_q == DROP) || ((state_q == FETCH) && !fault_q);
        imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
        ack_ok    = imem_req && imem_ack;

        if (redirect) begin
            id_valid_d   = 1'b0;
            held_instr_d = NOP_INSTR;
            held_pc_d    = '0;
            pc_d         = target_pc;
            fault_d      = target_misaligned;
            if (imem_req && !ack_ok) begin
                // Keep presenting the stale address until memory answers;
                // a redirect already in DROP only retargets the PC.
                state_d = DROP;
                if (state_q == FETCH) begin
                    drop_addr_d = pc_q;
                end
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    if (!stall) id_valid_d = 1'b0;
                end
                FETCH: begin
                    if (ack_ok) begin
                        pc_d = pc_q + PC_STEP;
                        if (stall) begin
                            held_instr_d = imem_rdata;
                            held_pc_d    = pc_q;
                            state_d      = HOLD;
                        end else begin
                            id_valid_d    = 1'b1;
                            id_instr_d    = imem_rdata;
                            id_pc_d       = pc_q;
                            id_pc_plus4_d = pc_q + PC_STEP;
                        end
                    end else if (!stall) begin
                        id_valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        id_valid_d    = 1'b1;
                        id_instr_d    = held_instr_q;
                        id_pc_d       = held_pc_q;
                        id_pc_plus4_d = held_pc_q + PC_STEP;
                        state_d       = FETCH;
                    end
                end
                DROP: begin
                    if (ack_ok) state_d = FETCH;
                    if (!stall) id_valid_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_opcode   = id_instr_q[6:0];
    assign id_funct3   = id_instr_q[14:12];
    assign id_funct7   = id_instr_q[31:25];
    assign fetch_fault = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. Directed scenarios plus a
//                randomized run compared against a queue-based model of the
//                expected instruction stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
    logic        fetch_fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus4(id_pc_plus4), .id_opcode(id_opcode),
        .id_funct3(id_funct3), .id_funct7(id_funct7),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00A0_0113;
            32'h8:   return 32'h00F0_0193;
            32'hC:   return 32'h0140_0213;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F13;
        endcase
    endfunction

    // Drive one cycle of inputs, then advance to just after the next edge.
    task automatic tick(input logic a, input logic s, input logic r, input logic [31:0] rpc);
        imem_ack    = a;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_rdata  = mem_word(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ack = 0; stall = 0; redirect = 0; redirect_pc = 0; imem_rdata = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_req: got %0b want 0", imem_req); end
        tick(0, 0, 0, 0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req: got req=%0b addr=%h want 1/0", imem_req, imem_addr); end
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        // Assert reset with a request outstanding; it must abandon it at once.
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        n_checks++; if ({id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault} !== {1'b0, 32'h13, 32'h0, 32'h0, 1'b0}) begin
            n_fail++; $display("FAIL reset_ifid: got v=%0b i=%h pc=%h p4=%h f=%0b want 0/00000013/0/0/0", id_valid, id_instr, id_pc, id_pc_plus4, fetch_fault);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_release_req: got %0b want 0", imem_req); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick(0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin n_fail++; $display("FAIL b2b_addr%0d: got req=%0b addr=%h want 1/%h", k, imem_req, imem_addr, 4 * k); end
            if (k > 0) begin
                n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * (k - 1)) || id_opcode !== 7'h13) begin
                    n_fail++; $display("FAIL b2b_id%0d: got v=%0b pc=%h op=%h want 1/%h/13", k, id_valid, id_pc, id_opcode, 4 * (k - 1));
                end
            end
            tick(1, 0, 0, 0);
        end
        n_checks++; if ({id_pc, id_instr, id_pc_plus4, id_funct3, id_funct7} !== {32'hC, 32'h0140_0213, 32'h10, 3'd0, 7'd0}) begin
            n_fail++; $display("FAIL b2b_last: got pc=%h i=%h p4=%h f3=%0d f7=%0d want C/01400213/10/0/0", id_pc, id_instr, id_pc_plus4, id_funct3, id_funct7);
        end
    endtask

    task automatic test_latency();
        do_reset();
        tick(0, 0, 0, 0);
        for (int n = 0; n < 2; n++) begin
            for (int w = 0; w < 3; w++) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * n)) begin n_fail++; $display("FAIL lat_stable%0d_%0d: got req=%0b addr=%h want 1/%h", n, w, imem_req, imem_addr, 4 * n); end
                n_checks++; if (id_valid !== (w == 0 && n > 0)) begin n_fail++; $display("FAIL lat_pulse%0d_%0d: got %0b want %0b", n, w, id_valid, (w == 0 && n > 0)); end
                tick(0, 0, 0, 0);
            end
            tick(1, 0, 0, 0);
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * n)) begin n_fail++; $display("FAIL lat_deliver%0d: got v=%0b pc=%h want 1/%h", n, id_valid, id_pc, 4 * n); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 0, 0);          // ack for 0x8 arrives while ID is stalled
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %0b want 0", i, imem_req); end
            n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4 || id_instr !== 32'h00A0_0113) begin
                n_fail++; $display("FAIL stall_frozen%0d: got v=%0b pc=%h i=%h want 1/4/00a00113", i, id_valid, id_pc, id_instr);
            end
            tick(0, 1, 0, 0);
        end
        tick(0, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h8 || id_instr !== 32'h00F0_0193) begin
            n_fail++; $display("FAIL stall_release: got v=%0b pc=%h i=%h want 1/8/00f00193", id_valid, id_pc, id_instr);
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_fail++; $display("FAIL stall_resume: got req=%0b addr=%h want 1/C", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        tick(0, 0, 0, 0);
        repeat (4) tick(1, 0, 0, 0);
        tick(0, 0, 1, 32'h100);
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got %0b want 0", id_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_fail++; $display("FAIL redir_drop_addr: got req=%0b addr=%h want 1/10", imem_req, imem_addr); end
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);          // stale 0x10 data returns here
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL redir_discard: got v=%0b pc=%h want 0", id_valid, id_pc); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_new_addr: got req=%0b addr=%h want 1/100", imem_req, imem_addr); end
        tick(1, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
            n_fail++; $display("FAIL redir_first: got v=%0b pc=%h i=%h want 1/100/%h", id_valid, id_pc, id_instr, mem_word(32'h100));
        end
    endtask

    task automatic test_wrap_priority();
        do_reset();
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 32'hFFFF_FFFC);
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_target: got v=%0b req=%0b addr=%h want 0/1/fffffffc", id_valid, imem_req, imem_addr);
        end
        tick(1, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'h0) begin
            n_fail++; $display("FAIL wrap_id: got v=%0b pc=%h p4=%h want 1/fffffffc/0", id_valid, id_pc, id_pc_plus4);
        end
        n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
        tick(1, 1, 1, 32'h40);     // redirect + ack + stall together
        n_checks++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_fail++; $display("FAIL prio_flush: got v=%0b req=%0b addr=%h want 0/1/40", id_valid, imem_req, imem_addr);
        end
        tick(1, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40) begin n_fail++; $display("FAIL prio_resume: got v=%0b pc=%h want 1/40", id_valid, id_pc); end
    endtask

    task automatic test_misalign();
        do_reset();
        tick(0, 0, 0, 0);
        tick(1, 0, 1, 32'h102);
`ifdef MISALIGN_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || id_valid !== 1'b0) begin
                n_fail++; $display("FAIL mis_fault%0d: got f=%0b req=%0b v=%0b want 1/0/0", i, fetch_fault, imem_req, id_valid);
            end
            tick(0, 0, 0, 0);
        end
        tick(0, 0, 1, 32'h200);
        n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL mis_clear: got f=%0b req=%0b addr=%h want 0/1/200", fetch_fault, imem_req, imem_addr);
        end
        tick(1, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h200) begin n_fail++; $display("FAIL mis_resume: got v=%0b pc=%h want 1/200", id_valid, id_pc); end
`else
        n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_fail++; $display("FAIL mis_align: got f=%0b req=%0b addr=%h want 0/1/100", fetch_fault, imem_req, imem_addr);
        end
        tick(1, 0, 0, 0);
        n_checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || fetch_fault !== 1'b0) begin
            n_fail++; $display("FAIL mis_deliver: got v=%0b pc=%h f=%0b want 1/100/0", id_valid, id_pc, fetch_fault);
        end
`endif
    endtask

    // Randomized run. The model tracks the program-order stream: the next
    // address the core should fetch, whether the outstanding reply is stale,
    // a queue of fetched-but-undelivered instructions and the expected IF/ID.
    task automatic test_random(input int ncyc);
        ent_t        q[$];
        ent_t        cur, item;
        logic [31:0] next_pc, prev_addr, rpc;
        bit          dropping, ev, prev_pend, busy, have, a, s, r;
        int          lat, wcnt, deliv;
        do_reset();
        next_pc = 0; dropping = 0; ev = 0; prev_pend = 0; busy = 0; deliv = 0;
        cur = '0; lat = 0; wcnt = 0; prev_addr = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (prev_pend) begin
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                    n_fail++; $display("FAIL rand_req_stable@%0d: got req=%0b addr=%h want 1/%h", c, imem_req, imem_addr, prev_addr);
                end
            end
            if (q.size() > 0) begin
                n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rand_hold_req@%0d: got %0b want 0", c, imem_req); end
            end
            n_checks++; if (id_valid !== ev) begin n_fail++; $display("FAIL rand_valid@%0d: got %0b want %0b", c, id_valid, ev); end
            if (ev) begin
                n_checks++;
                if ({id_pc, id_instr, id_pc_plus4, id_opcode, id_funct3, id_funct7} !==
                    {cur.pc, cur.instr, cur.pc + 32'd4, cur.instr[6:0], cur.instr[14:12], cur.instr[31:25]}) begin
                    n_fail++; $display("FAIL rand_ifid@%0d: got pc=%h i=%h p4=%h want pc=%h i=%h", c, id_pc, id_instr, id_pc_plus4, cur.pc, cur.instr);
                end
            end
            // memory responder with 0..3 cycles of latency
            a = 0;
            if (imem_req) begin
                if (!busy) begin lat = $urandom_range(0, 3); wcnt = 0; busy = 1; end
                a = (wcnt == lat);
                wcnt++;
                if (a) busy = 0;
            end
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else                           rpc = 32'($urandom_range(0, 255) * 4);
`ifndef MISALIGN_TRAP_EN
            rpc = rpc | 32'($urandom_range(0, 3));
`endif
            // reference model step
            have = 0;
            if (imem_req && a && !dropping && !r) begin
                n_checks++; if (imem_addr !== next_pc) begin n_fail++; $display("FAIL rand_fetch_addr@%0d: got %h want %h", c, imem_addr, next_pc); end
                item = {imem_addr, mem_word(imem_addr)};
                have = 1;
                next_pc = next_pc + 32'd4;
            end
            if (r) begin
                ev = 0;
                q.delete();
                next_pc = rpc & ~32'd3;
                dropping = imem_req && !a;
            end else begin
                if (imem_req && a && dropping) dropping = 0;
                if (s) begin
                    if (have) q.push_back(item);
                end else if (q.size() > 0) begin
                    cur = q.pop_front(); ev = 1; deliv++;
                end else if (have) begin
                    cur = item; ev = 1; deliv++;
                end else begin
                    ev = 0;
                end
            end
            prev_pend = imem_req && !a;
            prev_addr = imem_addr;
            tick(a, s, r, rpc);
        end
        n_checks++; if (deliv < ncyc / 20) begin n_fail++; $display("FAIL rand_progress: got %0d deliveries want >= %0d", deliv, ncyc / 20); end
        imem_ack = 0; stall = 0; redirect = 0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_latency();
        test_stall();
        test_redirect_pending();
        test_wrap_priority();
        test_misalign();
        test_random(3000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
